axi_optical_regbank: RTL and testbench
======================================

Name: axi_optical_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed four-register OpticalBus slave.
- Generalises register count and data width.
- Adds byte strobes and per-register read-only status mapping.
- Adds SLVERR on illegal access and per-register write strobes to the optical-bus core.
- Accepts AW and W independently, in either order.
- Sits between the PS AXI interconnect and the optical-bus datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy N_REGS <= 2^(C_S_AXI_ADDR_WIDTH-ADDR_LSB).
N_REGS, 8, number of implemented registers.
RO_MASK, 0 (N_REGS bits), bit i=1: register i is read-only and returns status_in slice i.
RESET_VALUE, 0, value loaded into every writable register at reset.
ADDR_LSB (derived), log2(C_S_AXI_DATA_WIDTH/8), first address bit of the register index.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  reset; synchronous, active-low.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
reg_out  out  N_REGS*C_S_AXI_DATA_WIDTH  flattened register contents; RO slices drive 0.
status_in  in  N_REGS*C_S_AXI_DATA_WIDTH  status values for RO registers; other slices unused.
wr_pulse  out  N_REGS  one-cycle strobe per register on a committed write.

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge):
  - All READY/VALID outputs, BRESP, RRESP, RDATA and wr_pulse go to 0.
  - Writable registers load RESET_VALUE.
  - Any in-flight transaction is dropped; no response is issued after reset.
  - READY outputs rise on the first edge after ARESETN=1.
- Register index: idx = addr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]; address bits below ADDR_LSB are ignored.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - AWREADY=1 in W_IDLE and W_HAVE_DATA.
  - WREADY=1 in W_IDLE and W_HAVE_ADDR.
  - Both READY signals are 0 in W_RESP.
  - W_IDLE: AW handshake alone -> W_HAVE_ADDR (address latched). W handshake alone -> W_HAVE_DATA (data and strobe latched). Both in the same cycle -> commit.
  - W_HAVE_ADDR + W handshake, or W_HAVE_DATA + AW handshake -> commit.
  - Commit edge:
    - Register idx updates byte-wise where WSTRB=1.
    - BVALID=1 from the next cycle; wr_pulse[idx]=1 for exactly that one cycle.
    - State -> W_RESP.
  - Write-to-committed-value latency is 1 cycle after the completing handshake.
  - W_RESP: BVALID stays high until BREADY; then -> W_IDLE. One write outstanding at most.
- Write response codes:
  - BRESP=OKAY (00) for an in-range writable idx.
  - BRESP=SLVERR (10) if idx >= N_REGS or RO_MASK[idx]=1; register unchanged and no wr_pulse.
  - WSTRB=0 on a legal register: OKAY, register unchanged, wr_pulse still fires.
- Read path, two states:
  - R_IDLE: ARREADY=1, RVALID=0. AR handshake -> RDATA/RRESP registered; RVALID=1 on the next cycle -> R_DATA.
  - R_DATA: ARREADY=0; hold RDATA, RRESP and RVALID until RREADY; then -> R_IDLE.
  - RDATA = register idx, or status_in slice idx if RO (sampled at the AR handshake edge).
  - Out of range: RDATA=0, RRESP=SLVERR.
- Read and write paths are independent and may be active in the same cycle.
- A read and a commit to the same register at the same edge: the read returns the pre-write value.
- BVALID/RVALID never drop without the matching READY.
- Outputs are unaffected by AWPROT/ARPROT.

Test Plan:
1. Defaults (N_REGS=8, RO_MASK=8'h80): write 1,2,…,7 to byte addresses 0x00–0x18 with WSTRB=F, then read back -> RDATA 1..7, all BRESP/RRESP=00, wr_pulse[i] high one cycle per write.
2. Register 1 = 0x11223344; write 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
3. Write to 0x1C (RO) -> BRESP=10, reg unchanged, no wr_pulse. Then status_in slice 7 = 0xDEADBEEF, read 0x1C -> 0xDEADBEEF, RRESP=00. Read with N_REGS=6 at 0x18 -> RDATA=0, RRESP=10.
4. W presented 3 cycles before AW to reg 2 (data 0x5A) -> WREADY drops after the W handshake; BVALID exactly 1 cycle after the AW handshake; reg 2 = 0x5A. Repeat with AW before W -> same result.
5. BREADY/RREADY held low 10 cycles -> BVALID/RVALID and data stable throughout, AWREADY/WREADY/ARREADY stay 0; completes on release.
6. Assert ARESETN=0 in W_HAVE_ADDR and in R_DATA -> next cycle all VALIDs 0, regs = RESET_VALUE, no BVALID issued after release.

Source files
------------

// File: rtl/axi_optical_regbank.sv
// axi_optical_regbank: AXI4-Lite register bank with byte strobes, RO status slots, SLVERR and per-register write pulses
module axi_optical_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int N_REGS = 8,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [N_REGS-1:0]                    wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IW = AW - ADDR_LSB;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [DW-1:0] regs [N_REGS];
  logic [IW-1:0] aw_idx, c_idx, ar_idx;
  logic [DW-1:0] w_data, c_data, r_val;
  logic [SW-1:0] w_strb, c_strb;
  logic [N_REGS-1:0] pulse_n;
  logic aw_hs, w_hs, ar_hs, commit, w_legal, r_ok;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                    S_AXI_ARADDR[ADDR_LSB-1:0], status_in};
  // Whichever half arrived first is taken from the latch, the other straight from the bus
  always_comb begin
    aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs = S_AXI_WVALID && S_AXI_WREADY;
    commit = (w_state == W_IDLE && aw_hs && w_hs) || (w_state == W_HAVE_ADDR && w_hs) ||
             (w_state == W_HAVE_DATA && aw_hs);
    c_idx = w_state == W_HAVE_ADDR ? aw_idx : S_AXI_AWADDR[AW-1:ADDR_LSB];
    c_data = w_state == W_HAVE_DATA ? w_data : S_AXI_WDATA;
    c_strb = w_state == W_HAVE_DATA ? w_strb : S_AXI_WSTRB;
    w_legal = 1'b0;
    pulse_n = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (c_idx == IW'(i)) w_legal = !RO_MASK[i];
      pulse_n[i] = commit && !RO_MASK[i] && c_idx == IW'(i);
    end
  end
  always_comb begin
    ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    ar_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];
    r_ok = 1'b0;
    r_val = '0;
    for (int i = 0; i < N_REGS; i++)
      if (ar_idx == IW'(i)) begin
        r_ok = 1'b1;
        r_val = RO_MASK[i] ? status_in[i*DW +: DW] : regs[i];
      end
  end
  always_ff @(posedge ACLK)
    for (int r = 0; r < N_REGS; r++)
      if (!ARESETN) regs[r] <= RO_MASK[r] ? '0 : RESET_VALUE;
      else if (pulse_n[r])
        for (int b = 0; b < SW; b++)
          if (c_strb[b]) regs[r][b*8 +: 8] <= c_data[b*8 +: 8];
  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = regs[g];
  end
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      w_state <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
      wr_pulse <= '0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      wr_pulse <= pulse_n;
      if (commit) begin
        w_state <= W_RESP;
        S_AXI_AWREADY <= 1'b0;
        S_AXI_WREADY <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP <= w_legal ? 2'b00 : 2'b10;
      end else
        case (w_state)
          W_IDLE:
            if (aw_hs) begin
              w_state <= W_HAVE_ADDR;
              aw_idx <= S_AXI_AWADDR[AW-1:ADDR_LSB];
              S_AXI_AWREADY <= 1'b0;
            end else if (w_hs) begin
              w_state <= W_HAVE_DATA;
              w_data <= S_AXI_WDATA;
              w_strb <= S_AXI_WSTRB;
              S_AXI_WREADY <= 1'b0;
            end else begin
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY <= 1'b1;
            end
          W_RESP:
            if (S_AXI_BREADY) begin
              w_state <= W_IDLE;
              S_AXI_BVALID <= 1'b0;
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY <= 1'b1;
            end
          default: ;
        endcase
    end
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      r_state <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else
      case (r_state)
        R_IDLE:
          if (ar_hs) begin
            r_state <= R_DATA;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA <= r_val;
            S_AXI_RRESP <= r_ok ? 2'b00 : 2'b10;
          end else S_AXI_ARREADY <= 1'b1;
        default:
          if (S_AXI_RREADY) begin
            r_state <= R_IDLE;
            S_AXI_RVALID <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
      endcase
endmodule

// File: tb/tb_axi_optical_regbank.sv
// tb_axi_optical_regbank: directed AXI4-Lite vectors with hand-computed expectations
module tb_axi_optical_regbank;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [5:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [255:0] reg_out, status_in;
  logic [7:0] wr_pulse;
  int n_cmp = 0, n_err = 0;
  axi_optical_regbank #(.N_REGS(8), .RO_MASK(8'h80)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input logic [7:0] ep, input int stall, input string tag);
    logic aw_go, w_go;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      @(negedge clk);
      aw_go = awvalid && awready;
      w_go = wvalid && wready;
      tick();
      if (aw_go) awvalid = 0;
      if (w_go) wvalid = 0;
    end
    chk($sformatf("%s_hs_timeout", tag), {awvalid, wvalid}, 0);
    awvalid = 0; wvalid = 0;
    chk($sformatf("%s_bvalid", tag), bvalid, 1);
    chk($sformatf("%s_bresp", tag), bresp, er);
    chk($sformatf("%s_pulse", tag), wr_pulse, ep);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk($sformatf("%s_stall_bvalid", tag), {bvalid, bresp}, {1'b1, er});
      chk($sformatf("%s_stall_ready", tag), {awready, wready, wr_pulse}, 0);
    end
    bready = 1; tick(); bready = 0;
    chk($sformatf("%s_bdone", tag), {bvalid, wr_pulse}, 0);
  endtask
  task automatic rd(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er,
                    input int stall, input string tag);
    logic go;
    araddr = a; arvalid = 1; go = 0;
    for (int i = 0; i < 20 && !go; i++) begin
      @(negedge clk);
      go = arready;
      tick();
    end
    arvalid = 0;
    chk($sformatf("%s_ar_timeout", tag), go, 1);
    chk($sformatf("%s_rvalid", tag), rvalid, 1);
    chk($sformatf("%s_rdata", tag), {rdata, rresp}, {ed, er});
    for (int i = 0; i < stall; i++) begin
      tick();
      chk($sformatf("%s_stall", tag), {rvalid, arready, rdata, rresp}, {1'b1, 1'b0, ed, er});
    end
    rready = 1; tick(); rready = 0;
    chk($sformatf("%s_rdone", tag), rvalid, 0);
  endtask
  initial begin
    awaddr = 0; araddr = 0; awprot = 3'b111; arprot = 3'b101; awvalid = 0; wvalid = 0;
    wdata = 0; wstrb = 0; bready = 0; arvalid = 0; rready = 0; status_in = '0;
    repeat (3) tick();
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid, bresp, rresp, wr_pulse}, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1; tick();
    chk("rel_ready", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < 7; i++) wr(6'(i * 4), 32'(i + 1), 4'hF, 2'b00, 8'(1 << i), 0, "t1_wr");
    for (int i = 0; i < 7; i++) rd(6'(i * 4), 32'(i + 1), 2'b00, 0, "t1_rd");
    wr(6'h04, 32'h11223344, 4'hF, 2'b00, 8'h02, 0, "t2_full");
    wr(6'h04, 32'hAABBCCDD, 4'b0101, 2'b00, 8'h02, 0, "t2_strb");
    rd(6'h04, 32'h11BB33DD, 2'b00, 0, "t2_rd");
    rd(6'h07, 32'h11BB33DD, 2'b00, 0, "t2_rd_lowbits");
    chk("t2_reg_out", reg_out[63:32], 32'h11BB33DD);
    wr(6'h1C, 32'h12345678, 4'hF, 2'b10, 8'h00, 0, "t3_ro_wr");
    chk("t3_ro_slice", reg_out[255:224], 0);
    status_in[255:224] = 32'hDEADBEEF;
    status_in[31:0] = 32'hFFFFFFFF;
    rd(6'h1C, 32'hDEADBEEF, 2'b00, 0, "t3_ro_rd");
    rd(6'h00, 32'h1, 2'b00, 0, "t3_rw_ignores_status");
    rd(6'h20, 32'h0, 2'b10, 0, "t3_oor_rd");
    wr(6'h3C, 32'hFFFFFFFF, 4'hF, 2'b10, 8'h00, 0, "t3_oor_wr");
    wr(6'h0C, 32'hFFFFFFFF, 4'h0, 2'b00, 8'h08, 0, "t3_nostrb");
    rd(6'h0C, 32'h4, 2'b00, 0, "t3_nostrb_rd");
    wdata = 32'h5A; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    chk("t4a_wready", wready, 1);
    tick(); wvalid = 0;
    chk("t4a_after_w", {wready, awready, bvalid}, 3'b010);
    repeat (2) tick();
    chk("t4a_wait", {wready, awready, bvalid, wr_pulse}, {3'b010, 8'h00});
    awaddr = 6'h08; awvalid = 1;
    tick(); awvalid = 0;
    chk("t4a_commit", {bvalid, bresp, wr_pulse}, {1'b1, 2'b00, 8'h04});
    chk("t4a_reg", reg_out[95:64], 32'h5A);
    bready = 1; tick(); bready = 0;
    chk("t4a_bdone", bvalid, 0);
    rd(6'h08, 32'h5A, 2'b00, 0, "t4a_rd");
    awaddr = 6'h08; awvalid = 1;
    tick(); awvalid = 0;
    chk("t4b_after_aw", {awready, wready, bvalid}, 3'b010);
    repeat (2) tick();
    chk("t4b_wait", {bvalid, wr_pulse}, 0);
    wdata = 32'hC3; wvalid = 1;
    tick(); wvalid = 0;
    chk("t4b_commit", {bvalid, bresp, wr_pulse}, {1'b1, 2'b00, 8'h04});
    chk("t4b_reg", reg_out[95:64], 32'hC3);
    bready = 1; tick(); bready = 0;
    rd(6'h08, 32'hC3, 2'b00, 0, "t4b_rd");
    wr(6'h10, 32'h77, 4'hF, 2'b00, 8'h10, 10, "t5_wr");
    rd(6'h10, 32'h77, 2'b00, 10, "t5_rd");
    awaddr = 6'h14; wdata = 32'h99; wstrb = 4'hF; araddr = 6'h14;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick(); awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t5_same_edge", {rvalid, rdata, bvalid}, {1'b1, 32'h6, 1'b1});
    chk("t5_same_reg", reg_out[191:160], 32'h99);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    rd(6'h14, 32'h99, 2'b00, 0, "t5_same_rd");
    awaddr = 6'h00; araddr = 6'h00; awvalid = 1; arvalid = 1;
    tick(); awvalid = 0; arvalid = 0;
    chk("t6_states", {awready, wready, rvalid, arready}, 4'b0110);
    rst_n = 0; tick();
    chk("t6_rst_valid", {bvalid, rvalid, wr_pulse}, 0);
    chk("t6_rst_ready", {awready, wready, arready}, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("t6_reg%0d", i), reg_out[i*32 +: 32], 0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_bvalid", {bvalid, rvalid}, 0);
    end
    chk("t6_ready", {awready, wready, arready}, 3'b111);
    rd(6'h00, 32'h0, 2'b00, 0, "t6_rd");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
